// File: rtl/stage5_field_extract_pipe.sv
// Stage-5 field extractor: slices one bit-field per message channel, gates it by
// enable/mux, tags a masked-compare hit and queues {field,hit} in a per-channel FIFO.
module stage5_field_extract_pipe #(
    parameter int NUM_CH        = 3,
    parameter int MSG_BITS      = 512,
    parameter int FIELD_MSB     = 47,
    parameter int FIELD_LSB     = 32,
    parameter int MUXC_BITS     = 4,
    parameter int MUX_DEFAULT   = 0,
    parameter int DEFAULT_VALUE = 0,
    parameter int DEPTH         = 4,
    parameter int CNT_BITS      = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         message_en,
    input  logic [NUM_CH-1:0]                            in_valid,
    output logic [NUM_CH-1:0]                            in_ready,
    input  logic [NUM_CH*MSG_BITS-1:0]                   message,
    input  logic [NUM_CH*MUXC_BITS-1:0]                  mux_ctrl,
    input  logic [FIELD_MSB-FIELD_LSB:0]                 match_val,
    input  logic [FIELD_MSB-FIELD_LSB:0]                 match_mask,
    output logic [NUM_CH*(FIELD_MSB-FIELD_LSB+1)-1:0]    field_out,
    output logic [NUM_CH-1:0]                            hit_out,
    output logic [NUM_CH-1:0]                            out_valid,
    input  logic [NUM_CH-1:0]                            out_ready,
    input  logic                                         cnt_clr,
    output logic [NUM_CH*CNT_BITS-1:0]                   hit_cnt,
    output logic [NUM_CH-1:0]                            overflow
);

    localparam int FW = FIELD_MSB - FIELD_LSB + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [FW-1:0]        DEF_FIELD  = FW'(DEFAULT_VALUE);
    localparam logic [MUXC_BITS-1:0] MUX_UNUSED = MUXC_BITS'(MUX_DEFAULT);
    localparam logic [AW:0]          OCC_FULL   = (AW+1)'(DEPTH);

    // Only the field window of each message is consumed; the rest is folded here.
    logic unused_msg_s;
    assign unused_msg_s = ^message;

    for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
        logic [FW-1:0]        field_mem_r [DEPTH];
        logic [DEPTH-1:0]     hit_mem_r;
        logic [AW-1:0]        wr_ptr_r;
        logic [AW-1:0]        rd_ptr_r;
        logic [AW:0]          occ_r;
        logic [AW:0]          occ_next_s;
        logic                 in_rdy_r;
        logic                 ovf_r;
        logic [CNT_BITS-1:0]  cnt_r;
        logic [MUXC_BITS-1:0] mux_s;
        logic                 gated_s;
        logic [FW-1:0]        value_s;
        logic                 hit_s;
        logic                 push_s;
        logic                 pop_s;

        // Gating, hit compare, handshake decode and next occupancy.
        always_comb begin
            mux_s   = mux_ctrl[i*MUXC_BITS +: MUXC_BITS];
            gated_s = message_en && (mux_s != MUX_UNUSED);
            if (gated_s) begin
                value_s = message[i*MSG_BITS + FIELD_LSB +: FW];
            end else begin
                value_s = DEF_FIELD;
            end
            hit_s  = gated_s && (((value_s ^ match_val) & match_mask) == '0);
            push_s = in_valid[i] && in_rdy_r;
            pop_s  = (occ_r != '0) && out_ready[i];
            case ({push_s, pop_s})
                2'b10:   occ_next_s = occ_r + (AW+1)'(1);
                2'b01:   occ_next_s = occ_r - (AW+1)'(1);
                default: occ_next_s = occ_r;
            endcase
        end

        // FIFO storage, pointers and occupancy; in_ready is registered from the
        // next occupancy so it never depends combinationally on out_ready.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    field_mem_r[k] <= '0;
                end
                hit_mem_r <= '0;
                wr_ptr_r  <= '0;
                rd_ptr_r  <= '0;
                occ_r     <= '0;
                in_rdy_r  <= 1'b0;
            end else begin
                if (push_s) begin
                    field_mem_r[wr_ptr_r] <= value_s;
                    hit_mem_r[wr_ptr_r]   <= hit_s;
                    wr_ptr_r              <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                occ_r    <= occ_next_s;
                in_rdy_r <= (occ_next_s < OCC_FULL);
            end
        end

        // Saturating hit counter; a clear wins over a coincident hit push.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= '0;
            end else if (cnt_clr) begin
                cnt_r <= '0;
            end else if (push_s && hit_s && (cnt_r != '1)) begin
                cnt_r <= cnt_r + CNT_BITS'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end

        // Sticky overflow: a message was offered while the FIFO refused it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf_r <= 1'b0;
            end else if (in_valid[i] && !in_rdy_r) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end

        assign in_ready[i]                    = in_rdy_r;
        assign out_valid[i]                   = (occ_r != '0);
        assign field_out[i*FW +: FW]          = field_mem_r[rd_ptr_r];
        assign hit_out[i]                     = hit_mem_r[rd_ptr_r];
        assign hit_cnt[i*CNT_BITS +: CNT_BITS] = cnt_r;
        assign overflow[i]                    = ovf_r;
    end

endmodule

// File: tb/tb_stage5_field_extract_pipe.sv
// Scoreboard bench for stage5_field_extract_pipe: directed pushes queue hand-computed
// {field,hit} pairs, a negedge monitor pops and compares every accepted output.
module tb_stage5_field_extract_pipe;

    localparam int NCH = 3;
    localparam int MB  = 512;
    localparam int FW  = 16;
    localparam int CB  = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                message_en;
    logic [NCH-1:0]      in_valid, in_ready, out_valid, out_ready, hit_out, overflow;
    logic [NCH*MB-1:0]   message;
    logic [NCH*4-1:0]    mux_ctrl;
    logic [FW-1:0]       match_val, match_mask;
    logic [NCH*FW-1:0]   field_out;
    logic                cnt_clr;
    logic [NCH*CB-1:0]   hit_cnt;

    // narrow-counter instance used only for saturation
    logic [0:0]          in_valid_sat, in_ready_sat, out_valid_sat, out_ready_sat;
    logic [0:0]          hit_out_sat, overflow_sat;
    logic [MB-1:0]       message_sat;
    logic [3:0]          mux_sat;
    logic [FW-1:0]       field_sat;
    logic                cnt_clr_sat;
    logic [3:0]          hit_cnt_sat;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [16:0] exp_q [NCH][$];

    always #5 clk = ~clk;

    stage5_field_extract_pipe dut (
        .clk(clk), .rst(rst), .message_en(message_en),
        .in_valid(in_valid), .in_ready(in_ready), .message(message),
        .mux_ctrl(mux_ctrl), .match_val(match_val), .match_mask(match_mask),
        .field_out(field_out), .hit_out(hit_out), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt),
        .overflow(overflow)
    );

    stage5_field_extract_pipe #(.NUM_CH(1), .CNT_BITS(4)) dut_sat (
        .clk(clk), .rst(rst), .message_en(message_en),
        .in_valid(in_valid_sat), .in_ready(in_ready_sat), .message(message_sat),
        .mux_ctrl(mux_sat), .match_val(match_val), .match_mask(match_mask),
        .field_out(field_sat), .hit_out(hit_out_sat), .out_valid(out_valid_sat),
        .out_ready(out_ready_sat), .cnt_clr(cnt_clr_sat), .hit_cnt(hit_cnt_sat),
        .overflow(overflow_sat)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output beat accepted this cycle must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    tests_run++;
                    if (exp_q[c].size() == 0) begin
                        tests_failed++;
                        $display("FAIL ch%0d_unexpected: got field 0x%0h hit %0d, expected none",
                                 c, field_out[c*FW +: FW], hit_out[c]);
                    end else begin
                        logic [16:0] e;
                        e = exp_q[c].pop_front();
                        if ({field_out[c*FW +: FW], hit_out[c]} !== e) begin
                            tests_failed++;
                            $display("FAIL ch%0d_data: got field 0x%0h hit %0d, expected field 0x%0h hit %0d",
                                     c, field_out[c*FW +: FW], hit_out[c], e[16:1], e[0]);
                        end
                    end
                end
            end
        end
    end

    task automatic set_msg(input int ch, input logic [15:0] f, input logic [3:0] mux);
        message[ch*MB +: MB]      = {16{$urandom()}};
        message[ch*MB + 32 +: FW] = f;
        mux_ctrl[ch*4 +: 4]       = mux;
    endtask

    task automatic push1(input int ch, input logic [15:0] f, input logic [3:0] mux,
                         input logic [16:0] exp);
        set_msg(ch, f, mux);
        check($sformatf("ch%0d_in_ready", ch), 64'(in_ready[ch]), 64'd1);
        exp_q[ch].push_back(exp);
        in_valid[ch] = 1'b1;
        @(posedge clk); #1;
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && g < 64) begin
            @(posedge clk); #1;
            g++;
        end
        tests_run++;
        if (g >= 64) begin
            tests_failed++;
            $display("FAIL drain_timeout: got %0d entries left, expected 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
        end
    endtask

    initial begin
        rst = 1'b1; message_en = 1'b1; in_valid = '0; out_ready = '0;
        message = '0; mux_ctrl = '0; match_val = '0; match_mask = '0; cnt_clr = 1'b0;
        in_valid_sat = '0; out_ready_sat = 1'b1; message_sat = '0; mux_sat = 4'd1;
        cnt_clr_sat = 1'b0;

        repeat (2) @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_field_out", 64'(field_out), 64'd0);
        check("rst_hit_out",   64'(hit_out),   64'd0);
        check("rst_hit_cnt",   64'(hit_cnt[63:0]), 64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd7);
        out_ready = 3'b111;

        // ch0 basic hit
        match_val = 16'h1234; match_mask = 16'hFFFF;
        push1(0, 16'h1234, 4'd2, {16'h1234, 1'b1});
        check("ch0_out_valid", 64'(out_valid[0]), 64'd1);
        check("ch0_hit_cnt", 64'(hit_cnt[0*CB +: CB]), 64'd1);
        wait_drain();

        // ch1 gated off by mux default: default value, never a hit
        match_mask = 16'h0000;
        push1(1, 16'hBEEF, 4'd0, {16'h0000, 1'b0});
        check("ch1_hit_cnt", 64'(hit_cnt[1*CB +: CB]), 64'd0);
        wait_drain();

        // ch2 stalled: four accepted, fifth refused and flagged
        out_ready[2] = 1'b0;
        match_mask = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ch2_in_ready_%0d", k), 64'(in_ready[2]), (k < 4) ? 64'd1 : 64'd0);
            set_msg(2, 16'h2000 + 16'(k), 4'd1);
            if (k < 4) exp_q[2].push_back({16'h2000 + 16'(k), 1'b1});
            in_valid[2] = 1'b1;
            @(posedge clk); #1;
        end
        in_valid[2] = 1'b0;
        check("ch2_overflow", 64'(overflow), 64'd4);
        check("ch2_hit_cnt", 64'(hit_cnt[2*CB +: CB]), 64'd4);
        check("ch2_out_valid_stalled", 64'(out_valid[2]), 64'd1);
        out_ready[2] = 1'b1;
        wait_drain();

        // ch0 streaming through pointer wrap, alternating hit/miss
        match_val = 16'hAAAA; match_mask = 16'hFFFF;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("ch0_stream_ready_%0d", k), 64'(in_ready[0]), 64'd1);
            if (k > 0) check($sformatf("ch0_stream_valid_%0d", k), 64'(out_valid[0]), 64'd1);
            set_msg(0, (k % 2 == 0) ? 16'hAAAA : 16'h5555, 4'd3);
            exp_q[0].push_back((k % 2 == 0) ? {16'hAAAA, 1'b1} : {16'h5555, 1'b0});
            in_valid[0] = 1'b1;
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        wait_drain();
        check("ch0_stream_hit_cnt", 64'(hit_cnt[0*CB +: CB]), 64'd11);
        check("stream_no_overflow", 64'(overflow), 64'd4);

        // clear coinciding with a hit push
        cnt_clr = 1'b1;
        push1(0, 16'hAAAA, 4'd3, {16'hAAAA, 1'b1});
        cnt_clr = 1'b0;
        check("clr_wins_ch0", 64'(hit_cnt[0*CB +: CB]), 64'd0);
        check("clr_all_ch2",  64'(hit_cnt[2*CB +: CB]), 64'd0);
        wait_drain();

        // saturation on the 4-bit counter instance
        match_mask = 16'h0000;
        in_valid_sat = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
        end
        check("sat_reach_max", 64'(hit_cnt_sat), 64'hF);
        @(posedge clk); #1;
        check("sat_hold_max", 64'(hit_cnt_sat), 64'hF);
        cnt_clr_sat = 1'b1;
        @(posedge clk); #1;
        cnt_clr_sat = 1'b0;
        in_valid_sat = 1'b0;
        check("sat_clr_wins", 64'(hit_cnt_sat), 64'd0);

        // reset with entries queued on ch1
        out_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) push1(1, 16'h1100 + 16'(k), 4'd5, {16'h1100 + 16'(k), 1'b1});
        check("ch1_queued_valid", 64'(out_valid[1]), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_field_out", 64'(field_out), 64'd0);
        check("midrst_overflow",  64'(overflow),  64'd0);
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(in_ready), 64'd7);
        out_ready = 3'b111;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("midrst_no_stale_%0d", k), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
